// File: rtl/misty1_sched.sv
// Two-requester round-robin scheduler in front of a MISTY1 round core.
// Skips the key load on a key hit and guards every core wait with a watchdog.
module misty1_sched #(
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic         clk,
    input  logic         nreset,
    input  logic         req0,
    input  logic         req1,
    input  logic         en_de0,
    input  logic         en_de1,
    input  logic [63:0]  din0,
    input  logic [63:0]  din1,
    input  logic [127:0] kin0,
    input  logic [127:0] kin1,
    output logic         ack0,
    output logic         ack1,
    output logic         done0,
    output logic         done1,
    output logic         err,
    output logic [63:0]  dout,
    output logic         owner,
    output logic         c_key_rdy,
    output logic         c_data_rdy,
    output logic         c_en_de,
    output logic [127:0] c_key_in,
    output logic [63:0]  c_data_in,
    input  logic [63:0]  c_data_out,
    input  logic         c_data_valid,
    input  logic         c_key_valid,
    input  logic         c_busy
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_KEY_GO   = 3'd1,
        S_KEY_WAIT = 3'd2,
        S_DAT_GO   = 3'd3,
        S_DAT_WAIT = 3'd4,
        S_RESP     = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [127:0]  key_q, key_d;
    logic [63:0]   blk_q, blk_d;
    logic [63:0]   dout_q, dout_d;
    logic          ende_q, ende_d;
    logic          owner_q, owner_d;
    logic          last_q, last_d;
    logic          key_loaded_q, key_loaded_d;
    logic          err_flag_q, err_flag_d;
    logic [7:0]    wdog_q, wdog_d;
    logic          run_q;
    logic          done0_q, done1_q, err_q, key_rdy_q, data_rdy_q;
    logic          grant_s, gsel_s;
    logic [127:0]  gkey_s;

    // run_q keeps ack low while reset is applied and for the first cycle after it.
    assign gsel_s  = (req0 && req1) ? ~last_q : req1;
    assign gkey_s  = gsel_s ? kin1 : kin0;
    assign grant_s = run_q && (state_q == S_IDLE) && (req0 || req1);
    assign ack0    = grant_s && !gsel_s;
    assign ack1    = grant_s && gsel_s;

    // Next-state, operand latching and watchdog logic.
    always_comb begin
        state_d      = state_q;
        key_d        = key_q;
        blk_d        = blk_q;
        dout_d       = dout_q;
        ende_d       = ende_q;
        owner_d      = owner_q;
        last_d       = last_q;
        key_loaded_d = key_loaded_q;
        err_flag_d   = err_flag_q;
        wdog_d       = wdog_q;
        case (state_q)
            S_IDLE: begin
                if (grant_s) begin
                    key_d      = gkey_s;
                    blk_d      = gsel_s ? din1 : din0;
                    ende_d     = gsel_s ? en_de1 : en_de0;
                    owner_d    = gsel_s;
                    last_d     = gsel_s;
                    err_flag_d = 1'b0;
                    if (key_loaded_q && (gkey_s == key_q)) begin
                        state_d = S_DAT_GO;
                    end else begin
                        state_d = S_KEY_GO;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_KEY_GO: begin
                key_loaded_d = 1'b0;
                state_d      = S_KEY_WAIT;
            end
            S_KEY_WAIT: begin
                // wdog_q == 0 marks the guard cycle: key_valid may still be stale from the last load.
                if ((wdog_q != 8'd0) && c_key_valid && !c_busy) begin
                    key_loaded_d = 1'b1;
                    state_d      = S_DAT_GO;
                end else if (wdog_q == TIMEOUT) begin
                    key_loaded_d = 1'b0;
                    dout_d       = 64'd0;
                    err_flag_d   = 1'b1;
                    state_d      = S_RESP;
                end else begin
                    state_d = S_KEY_WAIT;
                end
            end
            S_DAT_GO: begin
                state_d = S_DAT_WAIT;
            end
            S_DAT_WAIT: begin
                if (c_data_valid) begin
                    dout_d  = c_data_out;
                    state_d = S_RESP;
                end else if (wdog_q == TIMEOUT) begin
                    key_loaded_d = 1'b0;
                    dout_d       = 64'd0;
                    err_flag_d   = 1'b1;
                    state_d      = S_RESP;
                end else begin
                    state_d = S_DAT_WAIT;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (((state_d == S_KEY_WAIT) || (state_d == S_DAT_WAIT)) && (state_d != state_q)) begin
            wdog_d = 8'd0;
        end else if ((state_q == S_KEY_WAIT) || (state_q == S_DAT_WAIT)) begin
            wdog_d = wdog_q + 8'd1;
        end else begin
            wdog_d = wdog_q;
        end
    end

    // State, datapath and registered output flops.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q      <= S_IDLE;
            key_q        <= 128'd0;
            blk_q        <= 64'd0;
            dout_q       <= 64'd0;
            ende_q       <= 1'b0;
            owner_q      <= 1'b0;
            last_q       <= 1'b1;
            key_loaded_q <= 1'b0;
            err_flag_q   <= 1'b0;
            wdog_q       <= 8'd0;
            run_q        <= 1'b0;
            done0_q      <= 1'b0;
            done1_q      <= 1'b0;
            err_q        <= 1'b0;
            key_rdy_q    <= 1'b0;
            data_rdy_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            key_q        <= key_d;
            blk_q        <= blk_d;
            dout_q       <= dout_d;
            ende_q       <= ende_d;
            owner_q      <= owner_d;
            last_q       <= last_d;
            key_loaded_q <= key_loaded_d;
            err_flag_q   <= err_flag_d;
            wdog_q       <= wdog_d;
            run_q        <= 1'b1;
            done0_q      <= (state_d == S_RESP) && !owner_d;
            done1_q      <= (state_d == S_RESP) && owner_d;
            err_q        <= (state_d == S_RESP) && err_flag_d;
            key_rdy_q    <= (state_d == S_KEY_GO);
            data_rdy_q   <= (state_d == S_DAT_GO);
        end
    end

    assign done0      = done0_q;
    assign done1      = done1_q;
    assign err        = err_q;
    assign dout       = dout_q;
    assign owner      = owner_q;
    assign c_key_rdy  = key_rdy_q;
    assign c_data_rdy = data_rdy_q;
    assign c_en_de    = ende_q;
    assign c_key_in   = key_q;
    assign c_data_in  = blk_q;

endmodule

// File: tb/tb_misty1_sched.sv
// Scoreboard bench for misty1_sched with a behavioural round-core model.
module tb_misty1_sched;

    localparam logic [127:0] K1 = 128'h0011_2233_4455_6677_8899_aabb_ccdd_eeff;
    localparam logic [127:0] K2 = 128'h0000_0000_0000_0000_ffff_ffff_ffff_ffff;
    localparam logic [63:0]  P1 = 64'h0123_4567_89ab_cdef;
    localparam logic [63:0]  C1 = 64'h8b1d_a5f5_6ab3_d07c;
    localparam logic [63:0]  X2 = 64'hfedc_ba98_7654_3210;

    logic clk, nreset;
    logic req0, req1, en_de0, en_de1;
    logic [63:0] din0, din1;
    logic [127:0] kin0, kin1;
    logic ack0, ack1, done0, done1, err, owner;
    logic [63:0] dout;
    logic c_key_rdy, c_data_rdy, c_en_de;
    logic [127:0] c_key_in;
    logic [63:0] c_data_in, c_data_out;
    logic c_data_valid, c_key_valid, c_busy;

    misty1_sched #(.TIMEOUT(8'd16)) dut (
        .clk(clk), .nreset(nreset),
        .req0(req0), .req1(req1), .en_de0(en_de0), .en_de1(en_de1),
        .din0(din0), .din1(din1), .kin0(kin0), .kin1(kin1),
        .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1), .err(err),
        .dout(dout), .owner(owner),
        .c_key_rdy(c_key_rdy), .c_data_rdy(c_data_rdy), .c_en_de(c_en_de),
        .c_key_in(c_key_in), .c_data_in(c_data_in),
        .c_data_out(c_data_out), .c_data_valid(c_data_valid),
        .c_key_valid(c_key_valid), .c_busy(c_busy)
    );

    typedef struct packed {
        logic        own;
        logic [63:0] d;
        logic        e;
    } exp_t;

    exp_t exp_q[$];
    int   ack_log[$];
    int   checks = 0, errors = 0;
    int   cyc = 0, exp_total = 0, done_cnt = 0;
    int   n_key = 0, n_data = 0;
    int   ack0_cyc = 0, ack1_cyc = 0, done_cyc = 0, done0_cyc = 0;
    int   key_rdy_cyc = 0, data_rdy_cyc = 0;
    int   base;
    bit   hang = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Stand-in for the cipher: the published vector for K1, a simple mix otherwise.
    function automatic logic [63:0] core_f(input logic [127:0] k, input logic [63:0] d, input logic e);
        if (k == K1 && !e && d == P1) return C1;
        if (k == K1 && e && d == C1) return P1;
        return d ^ k[127:64] ^ k[63:0];
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Core model: key load takes 3 cycles, data takes 3 cycles unless hung.
    initial begin : core_model
        logic [127:0] lkey;
        logic [63:0]  res;
        int ktmr, dtmr;
        lkey = 128'd0; res = 64'd0; ktmr = 0; dtmr = 0;
        c_key_valid = 1'b0; c_busy = 1'b0; c_data_valid = 1'b0; c_data_out = 64'd0;
        forever begin
            @(posedge clk);
            #1;
            c_data_valid = 1'b0;
            if (ktmr > 0) begin
                ktmr--;
                if (ktmr == 0) begin c_key_valid = 1'b1; c_busy = 1'b0; end
            end
            if (dtmr > 0) begin
                dtmr--;
                if (dtmr == 0) begin c_data_valid = 1'b1; c_data_out = res; c_busy = 1'b0; end
            end
            if (c_key_rdy) begin lkey = c_key_in; c_key_valid = 1'b0; c_busy = 1'b1; ktmr = 3; end
            if (c_data_rdy) begin
                res = core_f(lkey, c_data_in, c_en_de);
                c_busy = 1'b1;
                if (!hang) dtmr = 3;
            end
        end
    end

    // Monitor: records handshakes and checks every done against the scoreboard.
    initial forever begin
        @(negedge clk);
        if (ack0 && ack1) check("ack_exclusive", 128'(1), 128'(0));
        if (ack0) begin ack0_cyc = cyc; ack_log.push_back(0); check("ack0_has_req", 128'(req0), 128'(1)); end
        if (ack1) begin ack1_cyc = cyc; ack_log.push_back(1); check("ack1_has_req", 128'(req1), 128'(1)); end
        if (c_key_rdy) begin n_key++; key_rdy_cyc = cyc; end
        if (c_data_rdy) begin n_data++; data_rdy_cyc = cyc; end
        if (done0 || done1) begin
            exp_t e;
            if (done0 && done1) check("done_exclusive", 128'(1), 128'(0));
            if (exp_q.size() == 0) begin
                check("unexpected_done", 128'(1), 128'(0));
            end else begin
                e = exp_q.pop_front();
                check("done_owner", 128'(done1), 128'(e.own));
                check("done_dout", 128'(dout), 128'(e.d));
                check("done_err", 128'(err), 128'(e.e));
            end
            done_cnt++;
            done_cyc = cyc;
            if (done0) done0_cyc = cyc;
        end
    end

    task automatic push_exp(input logic own, input logic [63:0] d, input logic e);
        exp_t x;
        x.own = own; x.d = d; x.e = e;
        exp_q.push_back(x);
        exp_total++;
    endtask

    task automatic drive(input bit r, input logic e, input logic [63:0] d, input logic [127:0] k);
        if (r) begin req1 = 1'b1; en_de1 = e; din1 = d; kin1 = k; end
        else   begin req0 = 1'b1; en_de0 = e; din0 = d; kin0 = k; end
    endtask

    task automatic wait_ack(input bit r, input bit drop);
        bit got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (r ? ack1 : ack0) got = 1'b1;
        end
        check(r ? "ack1_wait" : "ack0_wait", 128'(got), 128'(1));
        @(posedge clk);
        #1;
        if (drop) begin
            if (r) req1 = 1'b0; else req0 = 1'b0;
        end
    endtask

    task automatic wait_done();
        for (int i = 0; i < 400 && done_cnt < exp_total; i++) begin
            @(negedge clk);
            #1;
        end
        check("done_wait", 128'(done_cnt >= exp_total), 128'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 nreset = 1'b0;
        repeat (2) @(negedge clk);
        nreset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    function automatic int log_code();
        int c = 0;
        foreach (ack_log[i]) c = c * 10 + ack_log[i] + 1;
        return c;
    endfunction

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        nreset = 1'b0;
        req0 = 1'b0; req1 = 1'b0; en_de0 = 1'b0; en_de1 = 1'b0;
        din0 = 64'd0; din1 = 64'd0; kin0 = 128'd0; kin1 = 128'd0;
        #2;
        check("rst_ack", 128'({ack0, ack1}), 128'(0));
        check("rst_done_err", 128'({done0, done1, err}), 128'(0));
        check("rst_core_pulses", 128'({c_key_rdy, c_data_rdy, c_en_de}), 128'(0));
        check("rst_dout", 128'(dout), 128'(0));
        check("rst_owner", 128'(owner), 128'(0));
        check("rst_key_in", c_key_in, 128'(0));
        check("rst_data_in", 128'(c_data_in), 128'(0));
        repeat (2) @(negedge clk);
        nreset = 1'b1;
        @(posedge clk);
        #1;

        // Requester 0 encrypts with a fresh key: one key load, one data start.
        base = n_key;
        push_exp(1'b0, C1, 1'b0);
        drive(1'b0, 1'b0, P1, K1);
        wait_ack(1'b0, 1'b1);
        wait_done();
        check("t1_key_loads", 128'(n_key - base), 128'(1));
        check("t1_key_rdy_lat", 128'(key_rdy_cyc - ack0_cyc), 128'(1));

        // Requester 1 decrypts under the same key: no reload, data starts next cycle.
        base = n_key;
        push_exp(1'b1, P1, 1'b0);
        drive(1'b1, 1'b1, C1, K1);
        wait_ack(1'b1, 1'b1);
        wait_done();
        check("t2_key_loads", 128'(n_key - base), 128'(0));
        check("t2_data_rdy_lat", 128'(data_rdy_cyc - ack1_cyc), 128'(1));

        // Simultaneous requests after reset: requester 0 first, then 1.
        do_reset();
        ack_log.delete();
        base = n_key;
        push_exp(1'b0, X2, 1'b0);
        push_exp(1'b1, P1, 1'b0);
        drive(1'b0, 1'b0, P1, K2);
        drive(1'b1, 1'b1, C1, K1);
        wait_ack(1'b0, 1'b1);
        wait_ack(1'b1, 1'b1);
        wait_done();
        check("tie_order", 128'(log_code()), 128'(12));
        check("tie_ack1_spacing", 128'(ack1_cyc - done0_cyc), 128'(1));
        check("tie_key_loads", 128'(n_key - base), 128'(2));

        // Hung core: watchdog fires, err with dout 0, then the key is reloaded.
        hang = 1'b1;
        base = n_key;
        push_exp(1'b0, 64'd0, 1'b1);
        drive(1'b0, 1'b0, P1, K1);
        wait_ack(1'b0, 1'b1);
        wait_done();
        check("to_key_loads", 128'(n_key - base), 128'(0));
        check("to_latency", 128'(done_cyc - data_rdy_cyc), 128'(18));
        hang = 1'b0;
        base = n_key;
        push_exp(1'b0, C1, 1'b0);
        drive(1'b0, 1'b0, P1, K1);
        wait_ack(1'b0, 1'b1);
        wait_done();
        check("to_reload", 128'(n_key - base), 128'(1));

        // Reset in KEY_WAIT: outputs clear at once, the next request reloads the key.
        base = n_key;
        drive(1'b1, 1'b1, P1, K2);
        wait_ack(1'b1, 1'b1);
        @(posedge clk);
        #2 nreset = 1'b0;
        #1;
        check("kw_key_go_seen", 128'(n_key - base), 128'(1));
        check("kw_rst_pulses", 128'({ack0, ack1, done0, done1, err, c_key_rdy, c_data_rdy}), 128'(0));
        check("kw_rst_en_de", 128'(c_en_de), 128'(0));
        check("kw_rst_owner", 128'(owner), 128'(0));
        check("kw_rst_dout", 128'(dout), 128'(0));
        check("kw_rst_key_in", c_key_in, 128'(0));
        repeat (2) @(negedge clk);
        nreset = 1'b1;
        @(posedge clk);
        #1;
        base = n_key;
        push_exp(1'b1, X2, 1'b0);
        drive(1'b1, 1'b0, P1, K2);
        wait_ack(1'b1, 1'b1);
        wait_done();
        check("kw_reload", 128'(n_key - base), 128'(1));

        // req0 held while req1 pulses once: grants 0, 1, 0.
        ack_log.delete();
        push_exp(1'b0, C1, 1'b0);
        push_exp(1'b1, P1, 1'b0);
        push_exp(1'b0, C1, 1'b0);
        drive(1'b0, 1'b0, P1, K1);
        wait_ack(1'b0, 1'b0);
        drive(1'b1, 1'b1, C1, K1);
        wait_ack(1'b1, 1'b1);
        wait_ack(1'b0, 1'b1);
        wait_done();
        check("alt_order", 128'(log_code()), 128'(121));

        repeat (5) @(posedge clk);
        check("sb_empty", 128'(exp_q.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/misty1_sched.md
# misty1_sched

Two-requester scheduler in front of the MISTY1 three-clock round core. It arbitrates the single core round-robin between requester 0 and requester 1 and latches each request's operands. It reloads the key schedule only when the granted key differs from the loaded one, then sequences the core's key_rdy/data_rdy pulses and returns the 64-bit result to the owner. A watchdog reports a core that never answers.

## Interface
- TIMEOUT, 255: maximum wait cycles in any core-wait state before error (8-bit counter, 1..255).
- clk  in  1  system clock, all logic on rising edge.
- nreset  in  1  asynchronous active-low reset.
- req0 / req1  in  1  request level; held with operands until ackN.
- en_de0 / en_de1  in  1  0 = encrypt, 1 = decrypt.
- din0 / din1  in  64  input block.
- kin0 / kin1  in  128  key.
- ack0 / ack1  out  1  one-cycle pulse: request accepted, operands latched.
- done0 / done1  out  1  one-cycle pulse: dout valid for that requester.
- err  out  1  one-cycle pulse with doneN when the operation timed out; dout = 0 then.
- dout  out  64  result, held until the next done pulse.
- owner  out  1  requester currently or last granted.
- c_key_rdy, c_data_rdy  out  1  one-cycle start pulses to the core.
- c_en_de  out  1  latched en_de.
- c_key_in  out  128, c_data_in  out  64  latched operands.
- c_data_out  in  64, c_data_valid  in  1 (one-cycle pulse), c_key_valid  in  1 (level), c_busy  in  1.

## Operation
- Registers: key_reg[127:0], blk_reg[63:0], ende_reg, owner, last (round-robin pointer), key_loaded flag, wdog[7:0], and a 3-bit state.
- States: IDLE, KEY_GO, KEY_WAIT, DAT_GO, DAT_WAIT, RESP.
- IDLE: when no req is high, remain in IDLE. When exactly one req is high, grant it. When both are high, grant the requester != last. In the grant cycle: latch operands, assert ackN, set owner, set last = owner.
  - If key_loaded && kinN == key_reg, the next state is DAT_GO; otherwise the next state is KEY_GO.
- KEY_GO: drive c_key_rdy = 1 for exactly one cycle and clear key_loaded. Then go to KEY_WAIT.
- KEY_WAIT: a guard cycle ignores c_key_valid in the first cycle. After that, go to DAT_GO on c_key_valid && !c_busy and set key_loaded.
- DAT_GO: drive c_data_rdy = 1 for exactly one cycle, then go to DAT_WAIT.
- DAT_WAIT: on c_data_valid, capture c_data_out into dout and go to RESP.
- Watchdog: wdog clears on entry to KEY_WAIT or DAT_WAIT and increments each cycle in those states. When wdog == TIMEOUT:
  - clear key_loaded and set dout = 0;
  - go to RESP with the error flag set.
- RESP: pulse done[owner], and also err if the error flag is set. Return to IDLE, where a new grant can be made in the next cycle.
- c_key_in, c_data_in, and c_en_de are driven from the latched registers continuously.
- A request that drops before its ack is simply not granted. Operands after the ack are don't-care.
- A c_data_valid that arrives outside DAT_WAIT is ignored.

## Timing
- Reset (async, any state): state = IDLE. These outputs go to 0: ack0/1, done0/1, err, c_key_rdy, c_data_rdy, c_en_de. These registers go to 0: dout, owner, key_reg, blk_reg. last = 1, so requester 0 wins the first tie. key_loaded = 0, so the first operation always loads the key. A reset mid-operation abandons it with no done pulse.
- Latencies are counted from the ack cycle as cycle 0:
  - Key hit: c_data_rdy in cycle 1.
  - Key miss: c_key_rdy in cycle 1, KEY_WAIT from cycle 2, c_data_rdy in the cycle after key_valid is accepted.
  - done: one cycle after the c_data_valid cycle.
- Back-to-back: the minimum spacing between ack pulses is done + 1 cycle.
- Simultaneous req0 and req1 in IDLE: only one ack is issued. The loser stays pending and is granted next, unless the winner re-requests. Even then the loser wins, because last points at the winner.
- ack0 and ack1 are never high together; done0 and done1 are never high together.

## Test plan
- Requester 0: kin0 = 0011_2233_4455_6677_8899_aabb_ccdd_eeff, din0 = 0123_4567_89ab_cdef, en_de0 = 0 -> exactly one c_key_rdy pulse, then one c_data_rdy pulse, then done0 with dout = 8b1d_a5f5_6ab3_d07c; err = 0.
- Same key, requester 1 decrypts din1 = 8b1d_a5f5_6ab3_d07c with en_de1 = 1 -> no c_key_rdy pulse (key hit); c_data_rdy one cycle after ack1; done1 with dout = 0123_4567_89ab_cdef.
- req0 and req1 asserted in the same cycle after reset, with different keys -> ack0 first, then ack1 at done0 + 1. Two key loads occur. The done order is 0 then 1, and each dout is correct for its own key.
- Core model that never raises c_data_valid, TIMEOUT = 16 -> done0 and err both pulse 17–18 cycles after DAT_WAIT entry; dout = 0; key_loaded is cleared, so the next request reloads the key.
- nreset asserted while in KEY_WAIT -> all outputs are 0 immediately (asynchronously). The next request, even with the same key, issues c_key_rdy.
- req0 held high continuously while req1 pulses once -> grants alternate 0, 1, 0. No ack occurs without a matching req.
